// File: rtl/apu_wave_osc.sv
// apu_wave_osc: sine/square/saw/triangle oscillator with volume scaling, sample bus and PWM output.
// Define APU_OSC_NOISE_EN to add a 15-bit LFSR noise source on wave_sel=4.
module apu_wave_osc #(
  parameter int SAMPLE_W = 8,
  parameter int DIV_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                phase_reset,
  input  logic [DIV_W-1:0]    divider,
  input  logic [2:0]          wave_sel,
  input  logic [3:0]          volume,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                period_start,
  output logic                pwm
);
  localparam int PW = SAMPLE_W + 6;
  localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [6:0] SINE_ROM [64] = '{
    7'd1,   7'd4,   7'd7,   7'd10,  7'd13,  7'd16,  7'd19,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd49,  7'd52,  7'd55,  7'd58,  7'd61,  7'd63,  7'd66,  7'd69,
    7'd71,  7'd74,  7'd77,  7'd79,  7'd81,  7'd84,  7'd86,  7'd88,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };
  logic [DIV_W-1:0]    count;
  logic [7:0]          phase;
  logic                step, stepd, wrapd;
  logic [SAMPLE_W-1:0] pwm_cnt;
  logic [6:0]          sine_m;
  logic [7:0]          sine8, tri8, noise8, r8;
  logic                noise_hit;
  logic [SAMPLE_W-1:0] raw, out_s;
  logic [4:0]          vol1;
  logic signed [SAMPLE_W:0] s;
  logic signed [PW-1:0] prod;
  assign step = enable & (count >= divider);
`ifdef APU_OSC_NOISE_EN
  logic [14:0] lfsr;
  always_ff @(posedge clk)
    if (!rst_n) lfsr <= 15'h0001;
    else if (step) lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
  assign noise_hit = wave_sel == 3'd4;
  assign noise8 = {8{lfsr[0]}};
`else
  assign noise_hit = 1'b0;
  assign noise8 = 8'h00;
`endif
  // Quarter-wave ROM mirrored on phase[6], sign-folded on phase[7].
  assign sine_m = SINE_ROM[phase[6] ? ~phase[5:0] : phase[5:0]];
  assign sine8 = phase[7] ? {1'b0, ~sine_m} : {1'b1, sine_m};
  assign tri8 = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
  assign r8 = wave_sel == 3'd0 ? sine8 :
              wave_sel == 3'd1 ? {8{~phase[7]}} :
              wave_sel == 3'd2 ? phase :
              wave_sel == 3'd3 ? tri8 : noise8;
  assign raw = (wave_sel > 3'd3 && !noise_hit) ? MID :
               (wave_sel == 3'd1 && !phase[7]) ? '1 :
               SAMPLE_W'(r8) << (SAMPLE_W - 8);
  assign vol1 = {1'b0, volume} + 5'd1;
  assign s = $signed({1'b0, raw}) - $signed({1'b0, MID});
  assign prod = PW'(s) * PW'($signed({1'b0, vol1}));
  assign out_s = SAMPLE_W'(prod >>> 4) + MID;
  always_ff @(posedge clk)
    if (!rst_n) begin
      count <= '0;
      phase <= '0;
      stepd <= 1'b0;
      wrapd <= 1'b0;
      sample <= MID;
      sample_valid <= 1'b0;
      period_start <= 1'b0;
      pwm_cnt <= '0;
      pwm <= 1'b0;
    end else begin
      count <= (phase_reset || step) ? '0 : enable ? count + DIV_W'(1) : count;
      phase <= phase_reset ? '0 : step ? phase + 8'd1 : phase;
      stepd <= step & ~phase_reset;
      wrapd <= step & ~phase_reset & (phase == 8'hff);
      sample <= enable ? out_s : MID;
      sample_valid <= stepd & enable;
      period_start <= wrapd & enable;
      pwm_cnt <= pwm_cnt + SAMPLE_W'(1);
      pwm <= pwm_cnt < sample;
    end
endmodule

// File: tb/tb_apu_wave_osc.sv
// tb_apu_wave_osc: scoreboard bench for apu_wave_osc at SAMPLE_W=8 and SAMPLE_W=10.
module tb_apu_wave_osc;
  typedef struct {int s; bit cs; bit ps; bit cp; int gap;} ent_t;
  logic clk, rst_n, en8, en10, prst;
  logic [11:0] div;
  logic [2:0] ws;
  logic [3:0] vol;
  logic [7:0] s8;
  logic [9:0] s10;
  logic v8, v10, ps8, ps10, pwm8, pwm10;
  ent_t q[$];
  int total = 0, bad = 0, cyc = 0, last = 0;
  bit sel = 0, strict = 0;
  int sine_exp[4] = '{129, 255, 126, 0};

  apu_wave_osc #(.SAMPLE_W(8), .DIV_W(12)) u8 (
    .clk(clk), .rst_n(rst_n), .enable(en8), .phase_reset(prst), .divider(div),
    .wave_sel(ws), .volume(vol), .sample(s8), .sample_valid(v8),
    .period_start(ps8), .pwm(pwm8));
  apu_wave_osc #(.SAMPLE_W(10), .DIV_W(12)) u10 (
    .clk(clk), .rst_n(rst_n), .enable(en10), .phase_reset(prst), .divider(div),
    .wave_sel(ws), .volume(vol), .sample(s10), .sample_valid(v10),
    .period_start(ps10), .pwm(pwm10));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", n, a, e, cyc);
    end
  endtask

  task automatic push(input int s, input bit cs, input bit ps, input bit cp, input int gap);
    q.push_back('{s, cs, ps, cp, gap});
  endtask

  task automatic wait_empty(input int lim);
    for (int i = 0; i < lim && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Phase-reset with the oscillator held off, then run: first valid lands d+2 cycles after the mark.
  task automatic seg_start(input int d, input int w, input int v);
    @(negedge clk);
    div = 12'(d); ws = 3'(w); vol = 4'(v); en8 = 0; en10 = 0; prst = 1;
    @(negedge clk);
    prst = 0;
    if (sel) en10 = 1; else en8 = 1;
    last = cyc;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    begin
      bit v, ps;
      int sa;
      v = sel ? v10 : v8;
      ps = sel ? ps10 : ps8;
      sa = sel ? int'(s10) : int'(s8);
      if (strict) chk("no_valid", int'(v), 0);
      else if (v && q.size() != 0) begin
        ent_t e;
        e = q.pop_front();
        if (e.cs) chk("sample", sa, e.s);
        if (e.cp) chk("period_start", int'(ps), int'(e.ps));
        if (e.gap != 0) chk("valid_gap", cyc - last, e.gap);
      end
      if (v) last = cyc;
    end
  end

  initial begin
    logic [14:0] l;
    int h;
    rst_n = 0; en8 = 0; en10 = 0; prst = 0; div = 0; ws = 0; vol = 15;
    repeat (3) @(negedge clk);
    chk("rst_sample8", int'(s8), 128);
    chk("rst_valid8", int'(v8), 0);
    chk("rst_pstart8", int'(ps8), 0);
    chk("rst_pwm8", int'(pwm8), 0);
    chk("rst_sample10", int'(s10), 512);
    chk("rst_pwm10", int'(pwm10), 0);
    rst_n = 1;
    // noise first, so the LFSR starts from its reset seed
    seg_start(0, 4, 15);
    l = 15'h0001;
    for (int k = 1; k <= 32800; k++) begin
      l = {l[13:0], l[14] ^ l[13]};
`ifdef APU_OSC_NOISE_EN
      push(l[0] ? 255 : 0, 1, (k % 256) == 0, 1, k == 1 ? 2 : 1);
`else
      push(128, 1, (k % 256) == 0, 1, k == 1 ? 2 : 1);
`endif
    end
    wait_empty(40000);
    // sine, divider 0 then 3
    for (int d = 0; d <= 3; d += 3) begin
      seg_start(d, 0, 15);
      for (int k = 1; k <= 256; k++)
        push(sine_exp[(k % 256) / 64], (k % 64) == 0, (k % 256) == 0, 1, k == 1 ? d + 2 : d + 1);
      wait_empty(2000);
    end
    // divider lowered from 7 to 1 once count has reached 3
    seg_start(7, 2, 15);
    push(1, 1, 0, 1, 5);
    push(2, 1, 0, 1, 2);
    push(3, 1, 0, 1, 2);
    repeat (3) @(negedge clk);
    div = 1;
    wait_empty(100);
    // square at volume 7 and 0
    seg_start(0, 1, 7);
    for (int k = 1; k <= 256; k++) push((k % 256) < 128 ? 191 : 64, 1, (k % 256) == 0, 1, k == 1 ? 2 : 1);
    wait_empty(1000);
    seg_start(0, 1, 0);
    for (int k = 1; k <= 256; k++) push((k % 256) < 128 ? 135 : 120, 1, (k % 256) == 0, 1, k == 1 ? 2 : 1);
    wait_empty(1000);
    // enable dropped mid-period for 50 cycles
    seg_start(3, 2, 15);
    for (int k = 1; k <= 5; k++) push(k, 1, 0, 1, k == 1 ? 5 : 4);
    wait_empty(100);
    en8 = 0; strict = 1;
    repeat (50) @(negedge clk);
    chk("disabled_sample", int'(s8), 128);
    en8 = 1; strict = 0; last = cyc;
    for (int k = 6; k <= 10; k++) push(k, 1, 0, 1, 4);
    wait_empty(100);
    // phase_reset on the same cycle as a step
    seg_start(3, 2, 15);
    push(1, 1, 0, 1, 5);
    push(2, 1, 0, 1, 4);
    wait_empty(100);
    repeat (2) @(negedge clk);
    prst = 1; strict = 1;
    @(negedge clk);
    prst = 0;
    @(negedge clk);
    strict = 0; last = cyc;
    push(1, 1, 0, 1, 4);
    push(2, 1, 0, 1, 4);
    wait_empty(100);
    en8 = 0;
    // SAMPLE_W=10 saw
    sel = 1;
    seg_start(0, 2, 15);
    for (int k = 1; k <= 300; k++) push((k % 256) * 4, 1, (k % 256) == 0, 1, k == 1 ? 2 : 1);
    wait_empty(1000);
    // PWM extremes with the phase parked at 0
    seg_start(4095, 2, 15);
    repeat (8) @(negedge clk);
    chk("pwm_zero_sample", int'(s10), 0);
    h = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      h += int'(pwm10);
    end
    chk("pwm_zero_highs", h, 0);
    ws = 1;
    repeat (8) @(negedge clk);
    chk("pwm_full_sample", int'(s10), 1023);
    h = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      h += int'(pwm10);
    end
    chk("pwm_full_highs", h, 1023);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apu_wave_osc.md
Name: apu_wave_osc

Overview:
- Parametrised multi-waveform audio oscillator for the APU, and the successor to the single-channel sine PWM generator.
- Generates sine, square, saw or triangle waveforms from an 8-bit phase accumulator.
- Applies 4-bit volume scaling around midscale.
- Drives both a registered sample bus, for mixers, and an internal PWM output, for direct pin drive.

Parameters:
- SAMPLE_W, 8, sample/PWM resolution in bits. Legal range 8..12.
- DIV_W, 12, width of the frequency divider input.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- enable  in  1  oscillator run. Low: prescaler and phase hold, sample forced to midscale.
- phase_reset  in  1  synchronous: clears prescaler and phase
- divider  in  DIV_W  step period minus one. f_out = clk / (256*(divider+1)).
- wave_sel  in  3  0 sine, 1 square, 2 saw, 3 triangle, 4 noise (optional feature), 5-7 midscale
- volume  in  4  amplitude = (volume+1)/16
- sample  out  SAMPLE_W  registered unsigned sample; midscale MID = 2^(SAMPLE_W-1)
- sample_valid  out  1  one-cycle pulse when sample reflects a new phase
- period_start  out  1  one-cycle pulse, coincident with sample_valid, when phase wrapped 255->0
- pwm  out  1  registered PWM of sample

Behaviour:
- Clock and reset: rst_n is synchronous, active-low; clock is clk.
- Reset values: count=0, phase=0, lfsr=15'h0001, sample=MID, sample_valid=0, period_start=0, pwm_cnt=0, pwm=0.
- Prescaler step: step = enable & (count >= divider). On step: count<=0, phase<=phase+1 (mod 256). Otherwise, if enable: count<=count+1.
  - The >= comparison makes a divider lowered mid-count wrap on the next cycle rather than run to 2^DIV_W.
  - divider=0 steps every cycle.
- phase_reset: has priority over step. count<=0, phase<=0, no sample_valid for that cycle. The LFSR is unaffected.
- Raw waveform (8-bit r from phase p, then left-shifted by SAMPLE_W-8, zero-filled):
  - Sine: q = p[6] ? 63-p[5:0] : p[5:0]. m = ROM[q], 7-bit quarter wave with ROM[0]=1, ROM[63]=127, monotonic non-decreasing. ROM[i] = round(127*sin(pi*x_i/128)), x_i spaced linearly from 0.5-64*asin(1/254) to 63.5. r = p[7] ? 127-m : 128+m.
  - Square: r = p[7] ? 0 : 255. After shifting, square max is forced to 2^SAMPLE_W-1 (all ones).
  - Saw: r = p.
  - Triangle: r = p[7] ? ~{p[6:0],1'b0} : {p[6:0],1'b0}.
- Volume: s = raw - MID (signed, SAMPLE_W+1 bits). sv = (s*(volume+1)) >>> 4, arithmetic. out = sv + MID. volume=15 gives out = raw exactly.
- Sample register:
  - sample <= enable ? out : MID, every cycle.
  - Latency: one cycle from phase/wave_sel/volume change to sample.
  - sample_valid <= step & ~phase_reset, delayed one cycle so it is aligned with the new sample.
  - period_start <= same condition & (phase==255).
- PWM: pwm_cnt is a free-running SAMPLE_W-bit counter, wrapping. pwm <= (pwm_cnt < sample).
  - sample=0 gives constant low.
  - sample=2^W-1 gives high for all but one cycle per 2^W.
- Mode change: wave_sel and volume changes take effect on the next sample update; phase is not reset.
- enable low mid-period: count and phase freeze. Resume continues from the frozen state.

Optional Feature:
APU_OSC_NOISE_EN:
- Defined: wave_sel=4 selects noise.
  - 15-bit Fibonacci LFSR, feedback = lfsr[14]^lfsr[13], shifted left on each step.
  - r = lfsr[0] ? 255 : 0, then volume-scaled like the other waveforms.
  - The LFSR never reaches zero; reset seed is 1.
- Undefined: no LFSR logic is present, and wave_sel 4 outputs MID like 5-7.

Test Plan:
- SAMPLE_W=8, divider=0, wave_sel=0, volume=15 after reset -> sample_valid every cycle. Sample at phase 0/64/128/192 = 129/255/126/0. period_start once per 256 steps.
- divider=3 -> sample_valid every 4 cycles; period_start every 1024 cycles. With count=3 reached, change divider to 1 -> step on the next cycle, then every 2 cycles.
- wave_sel=1, volume=7 -> sample alternates 191 (phase<128) / 64 (phase>=128). volume=0 -> 135/120.
- enable=0 mid-period for 50 cycles -> sample=128, no sample_valid, phase unchanged on re-enable. phase_reset coincident with step -> phase=0, no sample_valid.
- SAMPLE_W=10, wave_sel=2, volume=15 -> sample = phase*4. PWM with sample=0 -> pwm low always. sample=1023 -> pwm high 1023 of every 1024 cycles.
- APU_OSC_NOISE_EN defined, wave_sel=4, divider=0 -> LFSR sequence period 32767, sample in {0,255}. Undefined -> sample=128 constant.
